// File: rtl/phase_sequencer.sv
// One-hot phase sequencer for the multi-cycle core: per-phase stall hold,
// memory-phase wait states, debug halt/single-step at retire, cycle/instret counters.
module phase_sequencer #(
  parameter int NPHASE    = 5,
  parameter int MEM_PHASE = 3,
  parameter int WAITW     = 4,
  parameter int CNTW      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPHASE-1:0] stall_in,
  input  logic [WAITW-1:0]  mem_wait_cfg,
  input  logic              halt_req,
  input  logic              step_req,
  output logic [NPHASE-1:0] phase,
  output logic              halted,
  output logic              retire,
  output logic [CNTW-1:0]   cycle,
  output logic [CNTW-1:0]   instret
);

  localparam logic [NPHASE-1:0] PH0 = {{(NPHASE-1){1'b0}}, 1'b1};

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [WAITW-1:0]  wait_cnt;
  logic              wait_done;
  logic              adv;
  logic [NPHASE-1:0] phase_rot;

  // Stall and wait are independent holds; both must clear to advance.
  assign wait_done = !phase[MEM_PHASE] || (wait_cnt == '0);
  assign adv       = (state == RUN) && !(|(phase & stall_in)) && wait_done;
  assign retire    = adv && phase[NPHASE-1];
  assign phase_rot = {phase[NPHASE-2:0], phase[NPHASE-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      phase    <= PH0;
      halted   <= 1'b0;
      wait_cnt <= '0;
      cycle    <= '0;
      instret  <= '0;
    end else begin
      case (state)
        RUN: begin
          cycle <= cycle + 1'b1;
          if (adv) begin
            if (retire) instret <= instret + 1'b1;
            // halt_req is only looked at on the instruction boundary
            if (retire && halt_req) begin
              state  <= HALT;
              phase  <= '0;
              halted <= 1'b1;
            end else begin
              phase <= phase_rot;
              if (phase_rot[MEM_PHASE]) wait_cnt <= mem_wait_cfg;
            end
          end else if (phase[MEM_PHASE] && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        HALT: begin
          if (!halt_req || step_req) begin
            state  <= RUN;
            phase  <= PH0;
            halted <= 1'b0;
            if (MEM_PHASE == 0) wait_cnt <= mem_wait_cfg;
          end
        end
        default: begin
          state  <= RUN;
          phase  <= PH0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench: per-cycle stimulus and expected outputs are queued together,
// then replayed against a 64-bit-counter instance and a 4-bit-counter instance.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  stall_in = '0;
  logic [3:0]  mem_wait_cfg = '0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic [4:0]  phase, s_phase;
  logic        halted, retire, s_halted, s_retire;
  logic [63:0] cycle, instret;
  logic [3:0]  s_cycle, s_instret;

  phase_sequencer #(.NPHASE(5), .MEM_PHASE(3), .WAITW(4), .CNTW(64)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .mem_wait_cfg(mem_wait_cfg),
    .halt_req(halt_req), .step_req(step_req), .phase(phase), .halted(halted),
    .retire(retire), .cycle(cycle), .instret(instret));

  phase_sequencer #(.NPHASE(5), .MEM_PHASE(3), .WAITW(4), .CNTW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .mem_wait_cfg(mem_wait_cfg),
    .halt_req(halt_req), .step_req(step_req), .phase(s_phase), .halted(s_halted),
    .retire(s_retire), .cycle(s_cycle), .instret(s_instret));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  stall;
    logic [3:0]  cfg;
    logic        halt;
    logic        step;
    logic [4:0]  ph;
    logic        ret;
    logic        hlt;
    logic [63:0] ecyc;
    logic [63:0] eins;
  } item_t;

  item_t       sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] e_cycle = '0;
  logic [63:0] e_instret = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] stall, input int cfg, input logic halt,
                      input logic step, input logic [4:0] ph, input logic ret, input logic hlt);
    item_t it;
    it.stall = stall; it.cfg = 4'(cfg); it.halt = halt; it.step = step;
    it.ph = ph; it.ret = ret; it.hlt = hlt; it.ecyc = e_cycle; it.eins = e_instret;
    sb_q.push_back(it);
    if (!hlt) e_cycle++;
    if (ret) e_instret++;
  endtask

  // One instruction; cfg_late is driven from phase 3 on, halt_req is high for phases hf..ht.
  task automatic push_instr(input int cfg, input int cfg_late, input int s2, input int s3,
                            input int hf, input int ht);
    for (int p = 0; p < 5; p++) begin
      int dur;
      dur = 1;
      if (p == 2) dur = 1 + s2;
      if (p == 3) dur = (cfg > s3) ? cfg + 1 : s3 + 1;
      for (int c = 0; c < dur; c++) begin
        logic [4:0] st;
        st = '0;
        if (p == 2 && c < s2) st[2] = 1'b1;
        if (p == 3 && c < s3) st[3] = 1'b1;
        push(st, (p >= 3) ? cfg_late : cfg, (p >= hf && p <= ht), 1'b0,
             5'(1 << p), (p == 4), 1'b0);
      end
    end
  endtask

  task automatic push_halted(input int n, input logic halt, input logic step);
    for (int i = 0; i < n; i++) push('0, 0, halt, step, '0, 1'b0, 1'b1);
  endtask

  // Starts and ends on a falling edge: drive, settle, compare, wait next falling edge.
  task automatic run_q();
    while (sb_q.size() > 0) begin
      item_t it;
      it = sb_q.pop_front();
      stall_in = it.stall; mem_wait_cfg = it.cfg; halt_req = it.halt; step_req = it.step;
      #1;
      chk("phase", phase, it.ph);
      chk("retire", retire, it.ret);
      chk("halted", halted, it.hlt);
      chk("cycle", cycle, it.ecyc);
      chk("instret", instret, it.eins);
      chk("s_phase", s_phase, it.ph);
      chk("s_instret", s_instret, it.eins[3:0]);
      chk("s_cycle", s_cycle, it.ecyc[3:0]);
      @(negedge clk);
    end
    stall_in = '0; halt_req = 1'b0; step_req = 1'b0;
  endtask

  task automatic do_reset();
    stall_in = '0; mem_wait_cfg = '0; halt_req = 1'b0; step_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_phase", phase, 5'b00001);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire, 0);
    chk("rst_cycle", cycle, 0);
    chk("rst_instret", instret, 0);
    e_cycle = '0; e_instret = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // free run: 20 cycles, retire every fifth
    for (int i = 0; i < 4; i++) push_instr(0, 0, 0, 0, 9, 9);
    run_q();
    chk("free_cycle", cycle, 20);
    chk("free_instret", instret, 4);

    // wait states, then cfg changed mid memory phase
    push_instr(3, 3, 0, 0, 9, 9);
    push_instr(3, 7, 0, 0, 9, 9);
    push_instr(0, 0, 0, 0, 9, 9);
    // stall overlapping the wait
    push_instr(3, 3, 2, 5, 9, 9);
    push_instr(1, 1, 0, 2, 9, 9);
    run_q();

    // halt raised in phase 1, two single steps, then release
    push_instr(0, 0, 0, 0, 1, 4);
    push_halted(3, 1'b1, 1'b0);
    push_halted(1, 1'b1, 1'b1);
    push_instr(2, 2, 0, 0, 0, 4);
    push_halted(2, 1'b1, 1'b0);
    push_halted(1, 1'b1, 1'b1);
    push_instr(0, 0, 0, 0, 0, 4);
    push_halted(1, 1'b1, 1'b0);
    push_halted(1, 1'b0, 1'b0);
    push_instr(0, 0, 0, 0, 9, 9);
    // halt pulse gone before the boundary, step ignored in run
    push_instr(0, 0, 0, 0, 1, 2);
    push_instr(0, 0, 0, 0, 9, 9);
    run_q();

    // reset in phase 3 with wait counter at 2
    push('0, 3, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0);
    push('0, 3, 1'b0, 1'b1, 5'b00010, 1'b0, 1'b0);
    push('0, 3, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0);
    push('0, 3, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0);
    run_q();
    chk("pre_rst_phase", phase, 5'b01000);
    do_reset();
    push_instr(2, 2, 0, 0, 9, 9);
    push_instr(0, 0, 0, 0, 9, 9);
    run_q();

    // 4-bit counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) push_instr(0, 0, 0, 0, 9, 9);
    run_q();
    chk("wrap_instret", s_instret, 1);
    chk("wrap_cycle", s_cycle, 5);
    chk("wrap_phase", s_phase, 5'b00001);
    chk("wide_instret", instret, 17);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
